// File: rtl/uart_rx_fifo_if.sv
// Host-side bundle of the UART receive FIFO: write strobe/data, FWFT read, status flags.
// level/almost_full exist only when RX_FIFO_LEVEL_EN is defined.
interface uart_rx_fifo_if #(
  parameter int DBIT = 8
`ifdef RX_FIFO_LEVEL_EN
  ,
  parameter int ADDR_W = 4
`endif
);
  logic            wr;
  logic [DBIT-1:0] w_data;
  logic            rd;
  logic [DBIT-1:0] r_data;
  logic            empty;
  logic            full;
  logic            overflow;
  logic            ovf_clr;
`ifdef RX_FIFO_LEVEL_EN
  logic [ADDR_W:0] level;
  logic            almost_full;
`endif

  modport master (
    output wr, w_data, rd, ovf_clr,
    input  r_data, empty, full, overflow
`ifdef RX_FIFO_LEVEL_EN
    ,
    input  level, almost_full
`endif
  );

  modport slave (
    input  wr, w_data, rd, ovf_clr,
    output r_data, empty, full, overflow
`ifdef RX_FIFO_LEVEL_EN
    ,
    output level, almost_full
`endif
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: circular register array, first-word-fall-through read, write-to-read latency 1 cycle.
// No backpressure: a write while full is dropped and sets sticky overflow; RX_FIFO_LEVEL_EN adds level/almost_full.
module uart_rx_fifo #(
  parameter int DBIT     = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DBIT-1:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              is_empty, is_full;
  logic              push, pop, drop;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);

  always_comb begin
    // A simultaneous read frees the slot, so a full FIFO still accepts the write.
    push       = bus.wr && (!is_full || bus.rd);
    pop        = bus.rd && !is_empty;
    drop       = bus.wr && is_full && !bus.rd;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)             overflow_d = 1'b1;
    else if (bus.ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.w_data;
  end

  assign bus.r_data   = mem_q[rd_ptr_q];
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.overflow = overflow_q;

`ifdef RX_FIFO_LEVEL_EN
  localparam logic [ADDR_W:0] AF_CNT = (ADDR_W + 1)'(AF_LEVEL);
  assign bus.level       = count_q;
  assign bus.almost_full = (count_q >= AF_CNT);
`else
  logic unused_af_level;
  assign unused_af_level = (AF_LEVEL != 0);
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus random stimulus for uart_rx_fifo, checked against a queue-based reference model.
// Level/almost_full checks are compiled in only with RX_FIFO_LEVEL_EN.
module tb_uart_rx_fifo;
  localparam int DBIT     = 8;
  localparam int ADDR_W   = 4;
  localparam int AF_LEVEL = 12;
  localparam int DEPTH    = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(
    .DBIT(DBIT)
`ifdef RX_FIFO_LEVEL_EN
    ,
    .ADDR_W(ADDR_W)
`endif
  ) bus ();

  uart_rx_fifo #(.DBIT(DBIT), .ADDR_W(ADDR_W), .AF_LEVEL(AF_LEVEL)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mq[$];
  bit m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_empty"}, 32'(bus.empty), 32'(mq.size() == 0));
    chk({tag, "_full"}, 32'(bus.full), 32'(mq.size() == DEPTH));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(m_ovf));
    if (mq.size() > 0) chk({tag, "_rdata"}, 32'(bus.r_data), 32'(mq[0]));
`ifdef RX_FIFO_LEVEL_EN
    chk({tag, "_level"}, 32'(bus.level), 32'(mq.size()));
    chk({tag, "_af"}, 32'(bus.almost_full), 32'(mq.size() >= AF_LEVEL));
`endif
  endtask

  // Drive one cycle from a negedge, apply the spec rules to the model at the edge, check at the next negedge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c, input string tag);
    bit popped;
    bit dropped;
    bus.wr = w; bus.w_data = d; bus.rd = r; bus.ovf_clr = c;
    @(posedge clk);
    popped  = r && (mq.size() > 0);
    if (popped) void'(mq.pop_front());
    dropped = 1'b0;
    if (w) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else dropped = 1'b1;
    end
    if (dropped) m_ovf = 1'b1;
    else if (c)  m_ovf = 1'b0;
    @(negedge clk);
    bus.wr = 1'b0; bus.rd = 1'b0; bus.ovf_clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    bus.wr = 1'b0; bus.w_data = '0; bus.rd = 1'b0; bus.ovf_clr = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    step(1'b1, 8'hA5, 1'b0, 1'b0, "single_wr");
    step(1'b0, 8'h00, 1'b1, 1'b0, "single_rd");

    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
    step(1'b1, 8'hFF, 1'b0, 1'b0, "drop_ff");
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    step(1'b0, 8'h00, 1'b0, 1'b1, "clr_after_drain");

    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill2");
    step(1'b1, 8'h55, 1'b1, 1'b0, "full_wr_rd");
    chk("first_after_full_rw", 32'(bus.r_data), 32'h01);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("last_is_55", 32'(bus.r_data), 32'h55);
      step(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
    end

    step(1'b1, 8'h3C, 1'b1, 1'b0, "empty_wr_rd");
    step(1'b0, 8'h00, 1'b1, 1'b0, "pop_3c");
    step(1'b0, 8'h00, 1'b1, 1'b0, "rd_on_empty");

    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, "wrap_wr");
      chk("wrap_order", 32'(bus.r_data), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_rd");
    end

    for (int i = 0; i < 16; i++) step(1'b1, 8'(i + 100), 1'b0, 1'b0, "fill3");
    step(1'b1, 8'hEE, 1'b0, 1'b0, "drop_set");
    step(1'b1, 8'hEF, 1'b0, 1'b1, "drop_with_clr");
    chk("ovf_kept", 32'(bus.overflow), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1, "clr_alone");
    chk("ovf_cleared", 32'(bus.overflow), 32'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain3");

    for (int i = 0; i < 400; i++) begin
      logic w, r, c;
      w = ($urandom_range(0, 99) < ((i < 200) ? 70 : 35));
      r = ($urandom_range(0, 99) < ((i < 200) ? 35 : 70));
      c = ($urandom_range(0, 15) == 0);
      step(w, 8'($urandom), r, c, "rand");
    end

    while (mq.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0, "pre_reset_drain");
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "hold5");
    reset = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    check_all("async_reset");
    @(negedge clk);
    bus.wr = 1'b1; bus.w_data = 8'h77;
    @(posedge clk);
    @(negedge clk);
    bus.wr = 1'b0;
    reset = 1'b0;
    check_all("wr_during_reset");
    step(1'b1, 8'h99, 1'b0, 1'b0, "post_reset_wr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
